io_dec_display: RTL and testbench

- Downstream consumer of the CPU's memory-mapped I/O output register. Each time the CPU writes a 32-bit value, this block converts it and drives the eight seven-segment displays HEX0..HEX7.
- Decimal mode uses a sequential double-dabble converter, one bit per clock.
- Hex mode shows the raw nibbles.
- Sits in top between cpu and the HEX pins, so displayed values match the CPU's computed register contents.

---
 rtl/io_dec_display.sv | 183 ++++++++++++++++++
 tb/tb_io_dec_display.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/io_dec_display.sv
// Seven-segment display driver for the CPU's I/O output register.
// Decimal mode runs a one-bit-per-clock double-dabble; hex mode shows raw nibbles.
module io_dec_display #(
    parameter int BLANK_LZ = 1,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hex_mode,
    output logic             busy,
    output logic             ovf,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX6,
    output logic [6:0]       HEX7
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;
    typedef logic [7:0][6:0] hex_arr_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [39:0] bcd_q, bcd_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        pend_hex_q, pend_hex_d;
    hex_arr_t    hex_q, hex_d;

    logic        go;
    logic        go_hex;
    logic [31:0] go_data;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Scan from the top digit down; a digit stays blank until the first non-zero one.
    function automatic hex_arr_t render(input logic [31:0] digs);
        hex_arr_t   r;
        logic       lead;
        logic [3:0] d;
        lead = 1'b1;
        for (int n = 7; n >= 0; n--) begin
            d = digs[n*4 +: 4];
            if (d != 4'd0) lead = 1'b0;
            if (BLANK_LZ != 0 && lead && n != 0) r[n] = SEG_BLANK;
            else                                 r[n] = seg7(d);
        end
        return r;
    endfunction

    function automatic logic [71:0] dd_step(input logic [71:0] v);
        logic [71:0] t;
        t = v;
        for (int i = 0; i < 10; i++) begin
            if (t[32 + 4*i +: 4] >= 4'd5) t[32 + 4*i +: 4] = t[32 + 4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_hex_d  = pend_hex_q;
        hex_d       = hex_q;

        // A fresh write beats a pending one; the pending one is then dropped.
        go      = wr_en | pend_q;
        go_hex  = wr_en ? hex_mode : pend_hex_q;
        go_data = wr_en ? wr_data  : pend_data_q;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (go) begin
                    if (go_hex) begin
                        hex_d = render(go_data);
                        ovf_d = 1'b0;
                    end else begin
                        shreg_d = go_data;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                {bcd_d, shreg_d} = dd_step({bcd_q, shreg_q});
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = S_LOAD;
            end
            S_LOAD: begin
                ovf_d   = |bcd_q[39:32];
                hex_d   = ovf_d ? {8{SEG_DASH}} : render(bcd_q[31:0]);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && wr_en) begin
            pend_d      = 1'b1;
            pend_data_d = wr_data;
            pend_hex_d  = hex_mode;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_hex_q  <= 1'b0;
            hex_q       <= {8{SEG_BLANK}};
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_hex_q  <= pend_hex_d;
            hex_q       <= hex_d;
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_io_dec_display.sv
// Bench for io_dec_display: an arithmetic display model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_io_dec_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        hex_mode = 1'b0;

    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [6:0]  ha0, ha1, ha2, ha3, ha4, ha5, ha6, ha7;
    logic [6:0]  hb0, hb1, hb2, hb3, hb4, hb5, hb6, hb7;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #10 clk = ~clk;

    io_dec_display #(.BLANK_LZ(1), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .hex_mode(hex_mode),
        .busy(busy_a), .ovf(ovf_a),
        .HEX0(ha0), .HEX1(ha1), .HEX2(ha2), .HEX3(ha3),
        .HEX4(ha4), .HEX5(ha5), .HEX6(ha6), .HEX7(ha7)
    );

    io_dec_display #(.BLANK_LZ(0), .WIDTH(32)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .hex_mode(hex_mode),
        .busy(busy_b), .ovf(ovf_b),
        .HEX0(hb0), .HEX1(hb1), .HEX2(hb2), .HEX3(hb3),
        .HEX4(hb4), .HEX5(hb5), .HEX6(hb6), .HEX7(hb7)
    );

    wire [55:0] disp_a = {ha7, ha6, ha5, ha4, ha3, ha2, ha1, ha0};
    wire [55:0] disp_b = {hb7, hb6, hb5, hb4, hb3, hb2, hb1, hb0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Digit n is blank when blanking is on, n>0 and the value is below base^n.
    function automatic logic [55:0] render(input longint v, input longint base, input bit blank);
        logic [55:0] r;
        longint p;
        p = 1;
        for (int n = 0; n < 8; n++) begin
            if (blank && n > 0 && v < p) r[n*7 +: 7] = 7'b1111111;
            else                         r[n*7 +: 7] = seg(int'((v / p) % base));
            p = p * base;
        end
        return r;
    endfunction

    // Behavioural model: a write either shows at once (hex) or after 33 more edges (decimal).
    int          m_left;
    longint      m_val;
    bit          m_pend, m_phex, m_h;
    logic [31:0] m_pdata, m_v;
    logic [55:0] exp_a, exp_b;
    bit          exp_busy, exp_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_pend = 0; exp_busy = 0; exp_ovf = 0;
            exp_a = {8{7'b1111111}}; exp_b = {8{7'b1111111}};
        end else if (m_left > 0) begin
            if (wr_en) begin m_pend = 1; m_pdata = wr_data; m_phex = hex_mode; end
            m_left--;
            if (m_left == 0) begin
                exp_busy = 0;
                if (m_val > 99999999) begin
                    exp_ovf = 1; exp_a = {8{7'b0111111}}; exp_b = {8{7'b0111111}};
                end else begin
                    exp_ovf = 0; exp_a = render(m_val, 10, 1); exp_b = render(m_val, 10, 0);
                end
            end
        end else if (wr_en || m_pend) begin
            m_v = wr_en ? wr_data : m_pdata;
            m_h = wr_en ? hex_mode : m_phex;
            m_pend = 0;
            if (m_h) begin
                exp_ovf = 0; exp_a = render(longint'(m_v), 16, 1); exp_b = render(longint'(m_v), 16, 0);
            end else begin
                m_val = longint'(m_v); m_left = 33; exp_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_disp_blank", {8'h0, disp_a}, {8'h0, exp_a});
            check("cyc_disp_noblank", {8'h0, disp_b}, {8'h0, exp_b});
            check("cyc_busy", {62'h0, busy_a, busy_b}, {62'h0, exp_busy, exp_busy});
            check("cyc_ovf", {62'h0, ovf_a, ovf_b}, {62'h0, exp_ovf, exp_ovf});
        end
    end

    // Write is sampled at the edge between the two negedges; returns just after that edge.
    task automatic write(input logic [31:0] v, input logic h);
        @(negedge clk);
        wr_en = 1'b1; wr_data = v; hex_mode = h;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_disp", {8'h0, disp_a}, {8'h0, {8{BL}}});
        check("reset_busy_ovf", {62'h0, busy_a, ovf_a}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        write(32'd12345, 1'b0);
        check("dec12345_busy_start", {63'h0, busy_a}, 64'h1);
        repeat (32) @(negedge clk);
        check("dec12345_busy_last", {63'h0, busy_a}, 64'h1);
        @(negedge clk);
        check("dec12345_disp", {8'h0, disp_a},
              {8'h0, BL, BL, BL, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010});
        check("dec12345_busy_end", {62'h0, busy_a, ovf_a}, 64'h0);

        write(32'hDEADBEEF, 1'b1);
        check("hex_deadbeef", {8'h0, disp_a},
              {8'h0, 7'b0100001, 7'b0000110, 7'b0001000, 7'b0100001,
                     7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
        check("hex_busy", {63'h0, busy_a}, 64'h0);

        write(32'h00000A00, 1'b1);
        check("hex_lz", {8'h0, disp_a}, {8'h0, BL, BL, BL, BL, BL, 7'b0001000, 7'b1000000, 7'b1000000});

        write(32'd100000000, 1'b0);
        repeat (33) @(negedge clk);
        check("ovf_disp", {8'h0, disp_a}, {8'h0, {8{DS}}});
        check("ovf_flag", {63'h0, ovf_a}, 64'h1);

        write(32'd99999999, 1'b0);
        repeat (33) @(negedge clk);
        check("nines_disp", {8'h0, disp_a}, {8'h0, {8{7'b0010000}}});
        check("nines_ovf", {63'h0, ovf_a}, 64'h0);

        write(32'd0, 1'b0);
        repeat (33) @(negedge clk);
        check("zero_blank", {8'h0, disp_a}, {8'h0, BL, BL, BL, BL, BL, BL, BL, 7'b1000000});
        check("zero_noblank", {8'h0, disp_b}, {8'h0, {8{7'b1000000}}});

        // Writes of 42 then 8 land while 7 converts; only 8 survives in the pending slot.
        write(32'd7, 1'b0);
        repeat (9) @(negedge clk);
        wr_en = 1'b1; wr_data = 32'd42; hex_mode = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'd8; hex_mode = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (21) @(negedge clk);
        check("pend_first_7", {8'h0, disp_a}, {8'h0, BL, BL, BL, BL, BL, BL, BL, 7'b1111000});
        @(negedge clk);
        check("pend_busy_again", {63'h0, busy_a}, 64'h1);
        repeat (33) @(negedge clk);
        check("pend_then_8", {8'h0, disp_a}, {8'h0, BL, BL, BL, BL, BL, BL, BL, 7'b0000000});

        // Asynchronous reset in the middle of a conversion.
        write(32'd12345, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_disp", {8'h0, disp_a}, {8'h0, {8{BL}}});
        check("async_rst_busy", {63'h0, busy_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        write(32'd6, 1'b0);
        repeat (32) @(negedge clk);
        check("post_rst_not_yet", {8'h0, disp_a}, {8'h0, {8{BL}}});
        @(negedge clk);
        check("post_rst_6", {8'h0, disp_a}, {8'h0, BL, BL, BL, BL, BL, BL, BL, 7'b0000010});

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
